o232c_fifo: RTL

O232C_FIFO -- requirements
Module: o232c_fifo

---
 rtl/o232c_fifo_pkg.sv | 21 ++
 rtl/o232c_fifo_tx_fifo.sv | 56 +++++
 rtl/o232c_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/o232c_fifo_pkg.sv
// Shared definitions for the FIFO-buffered RS-232C transmitter.
package o232c_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned FrameBits         = 10;
  localparam int unsigned DataBits          = FrameBits - 2;
  localparam int unsigned DefaultWaitCycles = 143;

  // Bits needed to count 0 .. cycles-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/o232c_fifo_tx_fifo.sv
// Byte FIFO with fall-through head output; depth is a power of two.
module tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);

  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Writes while full and reads while empty are ignored.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign full      = (r_count == FullCount);
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rptr];
  assign count     = r_count;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  // Pointers wrap naturally modulo depth; count tracks occupancy.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_do_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/o232c_fifo.sv
// FIFO-buffered 8N1 RS-232C transmitter.
module o232c_fifo
  import o232c_fifo_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles,
  parameter int unsigned DEPTH_LOG2  = 4
) (
  input  logic       clk,
  input  logic       xrst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned     CntW    = cnt_width(WAIT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);
  localparam logic [2:0]      BitLast = 3'(DataBits - 1);

  tx_state_e           r_state;
  logic [CntW-1:0]     r_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                r_busy;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_cnt_last;
  logic [7:0]          w_head;
  logic [DEPTH_LOG2:0] w_count;

  assign ready      = !w_full;
  assign w_push     = valid && !w_full;
  assign w_cnt_last = (r_cnt == CntLast);
  // Pop from idle, or at the end of a stop bit for back-to-back frames.
  assign w_pop      = !w_empty && ((r_state == StIdle) || ((r_state == StStop) && w_cnt_last));
  assign tx         = r_tx;
  assign busy       = r_busy;

  tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .xrst  (xrst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (r_state != StIdle) || (w_count != '0);
      // The line follows the state one cycle later.
      case (r_state)
        StStart: r_tx <= 1'b0;
        StData:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_cnt_last) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= StData;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StData: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == BitLast) begin
              r_bit_idx <= '0;
              r_state   <= StStop;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StStop: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= StStart;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
